// File: rtl/i2s_pkg.sv
// Shared types and sizing for the I2S slave receiver.
// Imported by every file of the receiver slice.
package i2s_pkg;

    // Default audio sample width.
    localparam int I2S_DATA_BIT = 16;

    // Bit counter width; must be able to hold DATA_BIT itself.
    localparam int I2S_CNT_W = $clog2(I2S_DATA_BIT + 1);

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } i2s_rx_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for an asynchronous input.
// Output is the last flop of the chain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = chain[STAGES-1];

endmodule

// File: rtl/i2s_slave_rx.sv
// Philips I2S slave receiver, oversampled in the fabric clock domain.
// Emits one coherent left/right pair per stereo frame.
module i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int DATA_BIT    = I2S_DATA_BIT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_sclk,
    input  logic                i_lrclk,
    input  logic                i_sd,
    output logic [DATA_BIT-1:0] o_audio_l,
    output logic [DATA_BIT-1:0] o_audio_r,
    output logic                o_audio_valid,
    output logic                o_frame_err,
    output logic                o_locked
);

    localparam int            CW       = cnt_width(DATA_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BIT);

    logic sclk_s;
    logic lrclk_s;
    logic sd_s;
    logic sclk_d;
    logic rise;

    logic smp_rise;
    logic smp_lr;
    logic smp_sd;

    logic lr_prev;
    logic ev_bnd;
    logic ev_bit;
    logic ev_lr;
    logic ev_sd;

    i2s_rx_state_t     state,     state_n;
    logic [CW-1:0]     bit_cnt,   bit_cnt_n;
    logic [DATA_BIT-1:0] shift_q, shift_n;
    logic [DATA_BIT-1:0] left_hold, left_hold_n;
    logic [DATA_BIT-1:0] audio_l_n;
    logic [DATA_BIT-1:0] audio_r_n;
    logic              valid_n;
    logic              err_n;
    logic              locked_n;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_sclk),
        .o_q     (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_lrclk),
        .o_q     (lrclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_sd),
        .o_q     (sd_s)
    );

    assign rise = sclk_s & ~sclk_d;

    // Detect sclk rise and capture lrclk/sd on that edge only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sclk_d   <= 1'b0;
            smp_rise <= 1'b0;
            smp_lr   <= 1'b0;
            smp_sd   <= 1'b0;
        end else begin
            sclk_d   <= sclk_s;
            smp_rise <= rise;
            if (rise) begin
                smp_lr <= lrclk_s;
                smp_sd <= sd_s;
            end
        end
    end

    // Classify each sampled edge as a slot boundary or a data bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lr_prev <= 1'b0;
            ev_bnd  <= 1'b0;
            ev_bit  <= 1'b0;
            ev_lr   <= 1'b0;
            ev_sd   <= 1'b0;
        end else begin
            ev_bnd <= smp_rise & (smp_lr != lr_prev);
            ev_bit <= smp_rise & (smp_lr == lr_prev);
            ev_lr  <= smp_lr;
            ev_sd  <= smp_sd;
            if (smp_rise) begin
                lr_prev <= smp_lr;
            end
        end
    end

    // Frame state, shift register and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= SYNC;
            bit_cnt       <= '0;
            shift_q       <= '0;
            left_hold     <= '0;
            o_audio_l     <= '0;
            o_audio_r     <= '0;
            o_audio_valid <= 1'b0;
            o_frame_err   <= 1'b0;
            o_locked      <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shift_q       <= shift_n;
            left_hold     <= left_hold_n;
            o_audio_l     <= audio_l_n;
            o_audio_r     <= audio_r_n;
            o_audio_valid <= valid_n;
            o_frame_err   <= err_n;
            o_locked      <= locked_n;
        end
    end

    // Next-state: alignment, word capture and short-slot rejection.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_q;
        left_hold_n = left_hold;
        audio_l_n   = o_audio_l;
        audio_r_n   = o_audio_r;
        valid_n     = 1'b0;
        err_n       = 1'b0;
        locked_n    = o_locked;

        if (ev_bnd) begin
            unique case (state)
                SYNC: begin
                    if (!ev_lr) begin
                        state_n   = LEFT;
                        bit_cnt_n = '0;
                        shift_n   = '0;
                    end
                end
                LEFT: begin
                    if (ev_lr && (bit_cnt == CNT_FULL)) begin
                        left_hold_n = shift_q;
                        state_n     = RIGHT;
                        bit_cnt_n   = '0;
                        shift_n     = '0;
                    end else begin
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                        state_n  = SYNC;
                    end
                end
                RIGHT: begin
                    if (!ev_lr && (bit_cnt == CNT_FULL)) begin
                        audio_l_n = left_hold;
                        audio_r_n = shift_q;
                        valid_n   = 1'b1;
                        locked_n  = 1'b1;
                        state_n   = LEFT;
                        bit_cnt_n = '0;
                        shift_n   = '0;
                    end else begin
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                        state_n  = SYNC;
                    end
                end
                default: begin
                    state_n  = SYNC;
                    locked_n = 1'b0;
                end
            endcase
        end else if (ev_bit && (state != SYNC) && (bit_cnt < CNT_FULL)) begin
            shift_n   = {shift_q[DATA_BIT-2:0], ev_sd};
            bit_cnt_n = bit_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for the I2S slave receiver.
// Drives a bit-level I2S stream and checks strobes, data and latency.
module tb_i2s_slave_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        lrclk = 1'b0;
    logic        sd = 1'b0;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        audio_valid;
    logic        frame_err;
    logic        locked;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    i2s_slave_rx #(
        .DATA_BIT    (16),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_sclk        (sclk),
        .i_lrclk       (lrclk),
        .i_sd          (sd),
        .o_audio_l     (audio_l),
        .o_audio_r     (audio_r),
        .o_audio_valid (audio_valid),
        .o_frame_err   (frame_err),
        .o_locked      (locked)
    );

    // Count strobes seen on the outputs.
    always @(negedge clk) begin
        if (audio_valid) n_valid++;
        if (frame_err) n_err++;
        if (audio_valid && frame_err) n_both++;
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chkn(input string tag, input int got, input int exp);
        total++;
        assert (got == exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
        #1;
    endtask

    // One sclk period: 4 clk low with lr/sd set, 4 clk high.
    task automatic send_bit(input logic lr, input logic b);
        @(negedge clk);
        lrclk = lr;
        sd = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    // Slot: boundary bit (junk), nd data bits MSB first, np pad bits.
    task automatic send_slot(input logic lr, input logic [15:0] w,
                             input int nd, input int np);
        send_bit(lr, 1'b1);
        for (int i = 0; i < nd; i++) send_bit(lr, w[15-i]);
        for (int i = 0; i < np; i++) send_bit(lr, 1'b1);
    endtask

    // Closing boundary bit with a random sclk phase; checks strobe timing.
    task automatic send_bit_lat(input logic lr, input logic b);
        int off;
        @(negedge clk);
        lrclk = lr;
        sd = b;
        repeat (4) @(negedge clk);
        off = int'($urandom_range(1, 9));
        @(posedge clk);
        #(off);
        sclk = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk1("lat_e3", audio_valid, 1'b0);
        @(posedge clk);
        #1 chk1("lat_e4", audio_valid, 1'b1);
        @(posedge clk);
        #1 chk1("lat_e5", audio_valid, 1'b0);
        @(negedge clk);
        sclk = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] wl;
        logic [15:0] wr;

        repeat (3) @(posedge clk);
        #1;
        chk16("rst_l", audio_l, 16'h0000);
        chk16("rst_r", audio_r, 16'h0000);
        chk1("rst_valid", audio_valid, 1'b0);
        chk1("rst_err", frame_err, 1'b0);
        chk1("rst_locked", locked, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 32-bit slots, first frame discarded.
        repeat (2) begin
            send_slot(1'b0, 16'hA55A, 16, 15);
            send_slot(1'b1, 16'h1234, 16, 15);
        end
        settle();
        chkn("t1_nvalid0", n_valid, 0);
        chk1("t1_unlocked", locked, 1'b0);
        send_slot(1'b0, 16'hA55A, 16, 15);
        settle();
        chkn("t1_nvalid1", n_valid, 1);
        chk16("t1_l1", audio_l, 16'hA55A);
        chk16("t1_r1", audio_r, 16'h1234);
        chk1("t1_locked1", locked, 1'b1);
        send_slot(1'b1, 16'h1234, 16, 15);
        send_slot(1'b0, 16'h8001, 16, 0);
        settle();
        chkn("t1_nvalid2", n_valid, 2);
        chk16("t1_l2", audio_l, 16'hA55A);
        chk16("t1_r2", audio_r, 16'h1234);
        chk1("t1_locked2", locked, 1'b1);
        chkn("t1_nerr", n_err, 0);

        // Exactly DATA_BIT bits per slot.
        for (int k = 0; k < 2; k++) begin
            send_slot(1'b1, 16'h7FFE, 16, 0);
            send_slot(1'b0, 16'h8001, 16, 0);
            settle();
            chkn("t2_nvalid", n_valid, 3 + k);
            chk16("t2_l", audio_l, 16'h8001);
            chk16("t2_r", audio_r, 16'h7FFE);
        end

        // Short right slot.
        send_slot(1'b1, 16'h7FFE, 12, 0);
        send_slot(1'b0, 16'h0F0F, 16, 0);
        settle();
        chkn("t3_nerr", n_err, 1);
        chk1("t3_unlocked", locked, 1'b0);
        chkn("t3_nvalid", n_valid, 4);
        chk16("t3_l_kept", audio_l, 16'h8001);
        chk16("t3_r_kept", audio_r, 16'h7FFE);
        send_slot(1'b1, 16'hF0F0, 16, 0);
        send_slot(1'b0, 16'hC3C3, 16, 0);
        settle();
        chkn("t3_skip_nvalid", n_valid, 4);
        chkn("t3_skip_nerr", n_err, 1);
        send_slot(1'b1, 16'h3C3C, 16, 0);
        w = 16'h5A5A;
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b0, w[15-i]);
        settle();
        chkn("t3_resync_nvalid", n_valid, 5);
        chk16("t3_l", audio_l, 16'hC3C3);
        chk16("t3_r", audio_r, 16'h3C3C);
        chk1("t3_relocked", locked, 1'b1);

        // Reset in the middle of a left slot.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk16("t4_l0", audio_l, 16'h0000);
        chk16("t4_r0", audio_r, 16'h0000);
        chk1("t4_locked0", locked, 1'b0);
        chk1("t4_valid0", audio_valid, 1'b0);
        chk1("t4_err0", frame_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 6; i < 16; i++) send_bit(1'b0, w[15-i]);
        send_slot(1'b1, 16'hA5A5, 16, 0);
        send_slot(1'b0, 16'h5A5A, 16, 0);
        settle();
        chkn("t4_nvalid_hold", n_valid, 5);
        chk16("t4_l_hold", audio_l, 16'h0000);
        send_slot(1'b1, 16'hA5A5, 16, 0);
        send_slot(1'b0, 16'h1357, 16, 0);
        settle();
        chkn("t4_nvalid", n_valid, 6);
        chk16("t4_l", audio_l, 16'h5A5A);
        chk16("t4_r", audio_r, 16'hA5A5);
        chk1("t4_locked", locked, 1'b1);

        // lrclk/sd activity without sclk edges.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lrclk = ~lrclk;
            sd = ~sd;
            repeat (2) @(negedge clk);
        end
        settle();
        chkn("t5_nvalid", n_valid, 6);
        chkn("t5_nerr", n_err, 1);
        chk1("t5_locked", locked, 1'b1);
        send_slot(1'b1, 16'h2468, 16, 0);
        send_bit_lat(1'b0, 1'b1);
        settle();
        chkn("t5_nvalid_next", n_valid, 7);
        chk16("t5_l", audio_l, 16'h1357);
        chk16("t5_r", audio_r, 16'h2468);

        // Latency across random sclk phases.
        for (int k = 0; k < 4; k++) begin
            wl = 16'(k * 16'h1111 + 16'h0F07);
            wr = ~wl;
            for (int i = 0; i < 16; i++) send_bit(1'b0, wl[15-i]);
            send_slot(1'b1, wr, 16, 0);
            send_bit_lat(1'b0, 1'b1);
            settle();
            chkn("t6_nvalid", n_valid, 8 + k);
            chk16("t6_l", audio_l, wl);
            chk16("t6_r", audio_r, wr);
        end

        chkn("both_high", n_both, 0);
        chkn("final_nerr", n_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_slave_rx.md
Name: i2s_slave_rx

Overview:
- I2S receiver that runs as a slave: it takes externally driven SCLK, LRCLK and SD pins from an ADC or another I2S master and oversamples them in the fabric clock domain.
- It deserializes each stereo frame into parallel left/right samples and emits one valid strobe per frame.
- It complements the master-side transmit chain and lets audio be captured from codecs that own the bit clock.
- Output format matches the DDFS/i2s_cdc sample interface, so the receiver drops straight into top-level audio paths.

Parameters:
- DATA_BIT, 16: sample width; must equal `DATA_BIT` from i2s_map.svh.
- SYNC_STAGES, 2: flip-flop stages per asynchronous input (minimum 2).

Ports:
- i_clk  input  1  fabric clock; the only clock.
- i_reset  input  1  synchronous, active-high reset.
- i_sclk  input  1  external bit clock, asynchronous to i_clk.
- i_lrclk  input  1  external word select, asynchronous; 0 = left, 1 = right.
- i_sd  input  1  external serial data, asynchronous.
- o_audio_l  output  DATA_BIT  last complete left sample.
- o_audio_r  output  DATA_BIT  last complete right sample.
- o_audio_valid  output  1  one-cycle strobe; the L/R pair is new and coherent.
- o_frame_err  output  1  one-cycle strobe; a short slot was detected and the frame was dropped.
- o_locked  output  1  high once frame alignment is acquired.

Behaviour:
- Reset values: all outputs 0; state SYNC; bit counter 0; shift register 0.
- Input conditioning:
  - Each of i_sclk, i_lrclk and i_sd passes through its own SYNC_STAGES chain.
  - One extra sclk stage gives an edge detect; rise = synced high and previous low.
  - i_lrclk and i_sd are sampled only on rise.
  - Requirement on the source: sclk high and low phases are each at least 2 i_clk periods.
- Protocol (Philips I2S):
  - LRCLK changes one SCLK before the MSB, and data is MSB first.
  - On a rise where the sampled lrclk differs from the previously sampled lrclk, that edge is a slot boundary. The sd bit on that edge is the LSB of the previous word and is ignored.
  - On every other rise: if bit_cnt < DATA_BIT, shift sd in from the LSB side and increment bit_cnt. Otherwise ignore sd, because longer slots (e.g. 32-bit slots) are legal.
- State machine: SYNC, LEFT, RIGHT.
  - SYNC: wait for a 1->0 lrclk boundary, then go to LEFT with bit_cnt = 0. o_locked = 0.
  - LEFT: at a 0->1 boundary, if bit_cnt == DATA_BIT, hold the shift register in left_hold and go to RIGHT. Otherwise pulse o_frame_err and go to SYNC.
  - RIGHT: at a 1->0 boundary, if bit_cnt == DATA_BIT:
    - load o_audio_l <= left_hold and o_audio_r <= shift register;
    - pulse o_audio_valid;
    - go to LEFT.
    Otherwise pulse o_frame_err, leave outputs unchanged, and go to SYNC.
  - o_locked = 1 in LEFT and RIGHT after the first valid frame. It clears on any frame_err.
- Boundary conditions:
  - A partial frame after reset or after an error is never output.
  - Glitch-free lrclk with no intervening sclk is not a boundary, because lrclk is evaluated only on rise.
  - Reset mid-frame discards any partial data and returns to SYNC.
  - bit_cnt saturates at DATA_BIT and cannot wrap.
  - o_frame_err and o_audio_valid are never high in the same cycle.
- Latency: o_audio_valid rises SYNC_STAGES + 2 i_clk cycles after the first i_clk edge that registers i_sclk high at the closing boundary. With the default that is 4 cycles.
- o_audio_l and o_audio_r are stable between strobes.

Decomposition:
- Package i2s_pkg holds:
  - typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t;
  - the bit-counter width, computed as $clog2(DATA_BIT+1).
- DATA_BIT stays in i2s_map.svh.
- One sub-module: sync_ff, a parameterized N-stage single-bit synchronizer, instantiated 3 times.

Test Plan:
- Reset, then 3 frames with 32-bit slots at sclk = i_clk/8, L = 16'hA55A and R = 16'h1234:
  - the first frame is discarded;
  - o_audio_valid pulses twice with l = A55A and r = 1234;
  - o_locked is 1 after the first strobe.
- 16-bit slots (exactly DATA_BIT bits), L = 16'h8001 and R = 16'h7FFE: each frame produces a strobe with exact values, proving boundary-bit exclusion.
- Inject a frame whose right slot has only 12 bits:
  - o_frame_err pulses once and o_locked drops;
  - there is no strobe for that frame and the outputs keep their previous values;
  - the next full frame is skipped while resyncing, and the following frame strobes correctly.
- Assert i_reset in the middle of a left slot: all outputs become 0 on the next cycle, and valid data resumes only after a new 1->0 lrclk boundary.
- Toggle i_lrclk and i_sd without any sclk edges: no strobe, no error, and the state is unchanged.
- Measure latency: o_audio_valid must be high exactly 4 i_clk cycles after i_sclk is first registered high at the closing boundary; repeat across random sclk-to-i_clk phase offsets.
